mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 111 +++++++++++
 tb/tb_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory controller that bridges single-word CPU loads/stores onto a RAM
// with a registered read port; out-of-range addresses finish with an error pulse.
module mem_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              addr_err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        DONE,
        ERR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              accept;
    logic              addr_out_of_range;

    assign accept            = (state == IDLE) && req;
    assign addr_out_of_range = (addr[31:ADDR_W] != '0);

    // MAR/MDR only move on an accepting edge so the RAM buses stay stable for the whole access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            mar   <= '0;
            mdr   <= '0;
            rdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                mar <= addr[ADDR_W-1:0];
                mdr <= wdata;
            end
            if (state == RD_CAPTURE) begin
                rdata <= ram_data_out;
            end
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        addr_err   = 1'b0;
        ram_read   = 1'b0;
        ram_write  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (req) begin
                    if (addr_out_of_range) begin
                        state_next = ERR;
                    end else if (we) begin
                        state_next = WR_ISSUE;
                    end else begin
                        state_next = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                // Strobes are masked by reset so an aborted access never reaches the RAM.
                ram_read   = !reset;
                state_next = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                state_next = DONE;
            end
            WR_ISSUE: begin
                ram_write  = !reset;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                addr_err   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ram_address = mar;
    assign ram_data_in = mdr;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed accesses push expected completions,
// a monitor pops them on every done pulse; a behavioural RAM sits on the RAM port.
module tb_mem_ctrl;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              busy;
    logic              addr_err;
    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ram_mem [0:511];
    logic [31:0] model_rdata;
    int          n_compared;
    int          n_mismatched;
    int          n_reads;
    int          n_writes;
    int          n_done;
    int          rd0;
    int          wr0;
    int          dn0;

    mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .done        (done),
        .busy        (busy),
        .addr_err    (addr_err),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural RAM with registered read; each word is preset to A500_0000 | index.
    initial begin
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 32'hA500_0000 | i;
        end
        ram_data_out = '0;
        n_reads      = 0;
        n_writes     = 0;
        forever begin
            @(posedge clock);
            if (ram_write) begin
                ram_mem[ram_address] <= ram_data_in;
                n_writes <= n_writes + 1;
            end
            if (ram_read) begin
                ram_data_out <= ram_mem[ram_address];
                n_reads <= n_reads + 1;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        n_done = 0;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                exp_t e;
                n_done++;
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_addr_err", {31'b0, addr_err}, {31'b0, e.err});
                    check_output("sb_rdata", rdata, e.data);
                end
            end
        end
    end

    // Called just after a negedge; returns one delta past the accepting edge E.
    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clock);
        #1;
        req = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_rdata  = '0;
        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_done", {31'b0, done}, 32'd0);
        check_output("rst_strobes", {30'b0, ram_read, ram_write}, 32'd0);
        check_output("rst_rdata", rdata, 32'd0);
        check_output("rst_ram_address", {23'b0, ram_address}, 32'd0);
        check_output("rst_ram_data_in", ram_data_in, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Store DEADBEEF to 0x010
        exp_q.push_back('{err: 1'b0, data: model_rdata});
        apply_stimulus(1'b1, 32'h010, 32'hDEADBEEF);
        @(negedge clock);
        check_output("st_ram_write", {31'b0, ram_write}, 32'd1);
        check_output("st_ram_read", {31'b0, ram_read}, 32'd0);
        check_output("st_ram_address", {23'b0, ram_address}, 32'h010);
        check_output("st_ram_data_in", ram_data_in, 32'hDEADBEEF);
        check_output("st_busy_e1", {31'b0, busy}, 32'd1);
        check_output("st_done_e1", {31'b0, done}, 32'd0);
        @(negedge clock);
        check_output("st_done_e2", {31'b0, done}, 32'd1);
        @(negedge clock);
        check_output("st_idle_busy", {31'b0, busy}, 32'd0);
        check_output("st_ram_mem", ram_mem[9'h010], 32'hDEADBEEF);

        // Load back from 0x010
        model_rdata = 32'hDEADBEEF;
        exp_q.push_back('{err: 1'b0, data: model_rdata});
        apply_stimulus(1'b0, 32'h010, 32'h0BAD0BAD);
        @(negedge clock);
        check_output("ld_ram_read", {31'b0, ram_read}, 32'd1);
        check_output("ld_busy_e1", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check_output("ld_ram_read_e2", {31'b0, ram_read}, 32'd0);
        check_output("ld_busy_e2", {31'b0, busy}, 32'd1);
        check_output("ld_done_e2", {31'b0, done}, 32'd0);
        @(negedge clock);
        check_output("ld_done_e3", {31'b0, done}, 32'd1);
        check_output("ld_busy_e3", {31'b0, busy}, 32'd1);
        check_output("ld_rdata_e3", rdata, 32'hDEADBEEF);
        @(negedge clock);
        check_output("ld_idle_busy", {31'b0, busy}, 32'd0);

        // Out-of-range address
        rd0 = n_reads;
        wr0 = n_writes;
        exp_q.push_back('{err: 1'b1, data: model_rdata});
        apply_stimulus(1'b0, 32'h0000_0200, 32'h55);
        @(negedge clock);
        check_output("err_done", {31'b0, done}, 32'd1);
        check_output("err_addr_err", {31'b0, addr_err}, 32'd1);
        check_output("err_strobes", {30'b0, ram_read, ram_write}, 32'd0);
        check_output("err_rdata", rdata, 32'hDEADBEEF);
        @(negedge clock);
        check_output("err_pulse_end", {30'b0, done, addr_err}, 32'd0);
        check_output("err_no_reads", n_reads - rd0, 32'd0);
        check_output("err_no_writes", n_writes - wr0, 32'd0);

        // Load from 0x000 with a request pulsed during RD_CAPTURE
        rd0 = n_reads;
        wr0 = n_writes;
        dn0 = n_done;
        model_rdata = 32'hA500_0000;
        exp_q.push_back('{err: 1'b0, data: model_rdata});
        apply_stimulus(1'b0, 32'h000, 32'h11111111);
        @(posedge clock);
        #1;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h020;
        wdata = 32'h99;
        @(posedge clock);
        #1;
        req = 1'b0;
        @(negedge clock);
        check_output("busy_req_done", {31'b0, done}, 32'd1);
        check_output("busy_req_rdata", rdata, 32'hA500_0000);
        repeat (3) @(negedge clock);
        check_output("busy_req_reads", n_reads - rd0, 32'd1);
        check_output("busy_req_writes", n_writes - wr0, 32'd0);
        check_output("busy_req_dones", n_done - dn0, 32'd1);

        // Reset asserted during the WR_ISSUE cycle of a store
        wr0 = n_writes;
        dn0 = n_done;
        apply_stimulus(1'b1, 32'h1FF, 32'h12345678);
        reset = 1'b1;
        @(negedge clock);
        check_output("rst_wr_strobe", {31'b0, ram_write}, 32'd0);
        @(negedge clock);
        model_rdata = '0;
        check_output("rst_wr_outputs", {28'b0, busy, done, addr_err, ram_write}, 32'd0);
        check_output("rst_wr_read", {31'b0, ram_read}, 32'd0);
        check_output("rst_wr_rdata", rdata, 32'd0);
        check_output("rst_wr_address", {23'b0, ram_address}, 32'd0);
        check_output("rst_wr_data_in", ram_data_in, 32'd0);
        check_output("rst_wr_ram_mem", ram_mem[9'h1FF], 32'hA500_01FF);
        check_output("rst_wr_no_write", n_writes - wr0, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_output("rst_wr_no_done", n_done - dn0, 32'd0);

        // Last-word round trip
        exp_q.push_back('{err: 1'b0, data: model_rdata});
        apply_stimulus(1'b1, 32'h1FF, 32'hCAFEF00D);
        repeat (3) @(negedge clock);
        check_output("edge_ram_mem", ram_mem[9'h1FF], 32'hCAFEF00D);
        model_rdata = 32'hCAFEF00D;
        exp_q.push_back('{err: 1'b0, data: model_rdata});
        apply_stimulus(1'b0, 32'h1FF, 32'h0);
        repeat (4) @(negedge clock);
        check_output("edge_rdata", rdata, 32'hCAFEF00D);

        // Held store request is accepted again on the first IDLE edge
        wr0 = n_writes;
        exp_q.push_back('{err: 1'b0, data: model_rdata});
        exp_q.push_back('{err: 1'b0, data: model_rdata});
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h005;
        wdata = 32'h0000_0505;
        repeat (4) @(posedge clock);
        #1;
        req = 1'b0;
        repeat (4) @(negedge clock);
        check_output("held_req_writes", n_writes - wr0, 32'd2);
        check_output("held_ram_mem", ram_mem[9'h005], 32'h0000_0505);

        repeat (3) @(negedge clock);
        check_output("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
